// File: rtl/vga_sram_arbiter_if.sv
// Shared-SRAM arbitration bus: the VGA read port, the CPU read/write port and
// the SRAM controller port, bundled so the arbiter and its environment see
// one connection. The arbiter takes the slave view; whatever surrounds it
// (requesters plus SRAM controller) takes the master view.
interface vga_sram_arbiter_if;
  // VGA scan-out read port
  logic        vga_req;
  logic [31:0] vga_addr;
  logic [31:0] vga_data;
  logic        vga_valid;
  logic        vga_busy;

  // CPU data port
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_sel;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        cpu_busy;

  // SRAM controller port
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_sel;
  logic [31:0] mem_rdata;
  logic        mem_busy;

  modport slave (
    input  vga_req, vga_addr,
    output vga_data, vga_valid, vga_busy,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_sel,
    output cpu_rdata, cpu_ack, cpu_busy,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
    input  mem_rdata, mem_busy
  );

  modport master (
    output vga_req, vga_addr,
    input  vga_data, vga_valid, vga_busy,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_sel,
    input  cpu_rdata, cpu_ack, cpu_busy,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
    output mem_rdata, mem_busy
  );
endinterface

// File: rtl/vga_sram_arbiter.sv
// Two-requester arbiter for the single-ported SRAM. VGA scan-out has
// priority; a 4-bit starvation counter caps how many VGA grants may be issued
// back to back while the CPU is waiting. One transfer is in flight at a time
// and it completes on the first edge where the SRAM reports mem_busy=0.
module vga_sram_arbiter #(
  parameter int STARVE_MAX = 8
) (
  input  logic                 clk,
  input  logic                 nrst,
  vga_sram_arbiter_if.slave    bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    VGA_XFER = 2'd1,
    CPU_XFER = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  starve_cnt;

  logic [31:0] vga_data_q;
  logic        vga_valid_q;
  logic [31:0] cpu_rdata_q;
  logic        cpu_ack_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_sel_q;

  logic        vga_elig;
  logic        cpu_elig;
  logic        vga_win;
  logic        cpu_win;

  // Grant decision. A requester whose completion pulse is showing this cycle
  // is still holding req for the request that just finished, so it is not
  // eligible; that keeps a finished request from being served twice.
  always_comb begin
    vga_elig = bus.vga_req & ~vga_valid_q;
    cpu_elig = bus.cpu_req & ~cpu_ack_q;
    vga_win  = (state == IDLE) & vga_elig &
               ((starve_cnt < STARVE_LIM) | ~cpu_elig);
    cpu_win  = (state == IDLE) & ~vga_win & cpu_elig;
  end

  // Arbitration FSM with all bus outputs registered; reset abandons any
  // transfer in flight without acknowledging it.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      starve_cnt  <= 4'd0;
      vga_data_q  <= 32'd0;
      vga_valid_q <= 1'b0;
      cpu_rdata_q <= 32'd0;
      cpu_ack_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_sel_q   <= 4'd0;
    end else begin
      vga_valid_q <= 1'b0;
      cpu_ack_q   <= 1'b0;

      // The counter only measures a continuous CPU wait; any cycle without a
      // CPU request, or the CPU finally winning, starts it over.
      if (!bus.cpu_req) begin
        starve_cnt <= 4'd0;
      end else if (cpu_win) begin
        starve_cnt <= 4'd0;
      end else if (vga_win && (starve_cnt < STARVE_LIM)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end

      case (state)
        IDLE: begin
          if (vga_win) begin
            state      <= VGA_XFER;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= bus.vga_addr;
            mem_sel_q  <= 4'hF;
          end else if (cpu_win) begin
            state       <= CPU_XFER;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.cpu_we;
            mem_addr_q  <= bus.cpu_addr;
            mem_wdata_q <= bus.cpu_wdata;
            mem_sel_q   <= bus.cpu_sel;
          end else begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end

        VGA_XFER: begin
          if (!bus.mem_busy) begin
            vga_data_q  <= bus.mem_rdata;
            vga_valid_q <= 1'b1;
            state       <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
          end
        end

        CPU_XFER: begin
          if (!bus.mem_busy) begin
            // Writes leave the last read data in place.
            if (!mem_we_q) begin
              cpu_rdata_q <= bus.mem_rdata;
            end
            cpu_ack_q <= 1'b1;
            state     <= IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

  // Busy flags are the only combinational outputs: pending and not yet done.
  assign bus.vga_busy  = bus.vga_req & ~vga_valid_q;
  assign bus.cpu_busy  = bus.cpu_req & ~cpu_ack_q;

  assign bus.vga_data  = vga_data_q;
  assign bus.vga_valid = vga_valid_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_sel   = mem_sel_q;

endmodule

// File: tb/tb_vga_sram_arbiter.sv
// Bench for vga_sram_arbiter: a table of single transactions, hand-written
// sequences for simultaneous requests and reset in flight, then randomized
// traffic checked against a transaction-level arbitration model.
module tb_vga_sram_arbiter;
  localparam int STARVE_MAX = 8;

  logic tb_clk = 1'b0;
  logic nrst;
  always #20 tb_clk = ~tb_clk;

  vga_sram_arbiter_if bus();

  vga_sram_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk  (tb_clk),
    .nrst (nrst),
    .bus  (bus)
  );

  // SRAM behavioural model: read data is always presented for mem_addr.
  logic [31:0] sram [64];
  assign bus.mem_rdata = sram[bus.mem_addr[5:0]];

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_cpu_rdata;

  typedef struct {
    bit          is_cpu;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          stall;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // One clock: commit any SRAM write completing on this edge, then settle.
  task automatic tick();
    logic        w;
    logic [5:0]  wa;
    logic [31:0] wd;
    logic [3:0]  ws;
    w  = bus.mem_req & ~bus.mem_busy & bus.mem_we & nrst;
    wa = bus.mem_addr[5:0];
    wd = bus.mem_wdata;
    ws = bus.mem_sel;
    @(posedge tb_clk);
    if (w) sram[wa] = merge(sram[wa], wd, ws);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [3:0] esel;
    logic       ewe;
    esel = v.is_cpu ? v.sel : 4'hF;
    ewe  = v.is_cpu & v.we;
    if (v.is_cpu) begin
      bus.cpu_req = 1'b1; bus.cpu_we = v.we; bus.cpu_addr = v.addr;
      bus.cpu_wdata = v.wdata; bus.cpu_sel = v.sel;
    end else begin
      bus.vga_req = 1'b1; bus.vga_addr = v.addr;
    end
    bus.mem_busy = (v.stall > 0);
    #1;
    chk($sformatf("v%0d busy_out", idx), v.is_cpu ? bus.cpu_busy : bus.vga_busy, 1);
    tick();
    for (int s = 0; s <= v.stall; s++) begin
      chk($sformatf("v%0d c%0d mem_req", idx, s), bus.mem_req, 1);
      chk($sformatf("v%0d c%0d mem_addr", idx, s), bus.mem_addr, v.addr);
      chk($sformatf("v%0d c%0d mem_we", idx, s), bus.mem_we, ewe);
      chk($sformatf("v%0d c%0d mem_sel", idx, s), bus.mem_sel, esel);
      if (ewe) chk($sformatf("v%0d c%0d mem_wdata", idx, s), bus.mem_wdata, v.wdata);
      chk($sformatf("v%0d c%0d early_done", idx, s), {bus.vga_valid, bus.cpu_ack}, 0);
      bus.mem_busy = (s < v.stall);
      tick();
    end
    chk($sformatf("v%0d done_pulse", idx), {bus.vga_valid, bus.cpu_ack}, v.is_cpu ? 2'b01 : 2'b10);
    chk($sformatf("v%0d mem_req_after", idx), bus.mem_req, 0);
    if (!v.is_cpu) chk($sformatf("v%0d vga_data", idx), bus.vga_data, v.exp_data);
    if (v.is_cpu && !v.we) exp_cpu_rdata = v.exp_data;
    chk($sformatf("v%0d cpu_rdata", idx), bus.cpu_rdata, exp_cpu_rdata);
    chk($sformatf("v%0d busy_in_done", idx), v.is_cpu ? bus.cpu_busy : bus.vga_busy, 0);
    tick();
    chk($sformatf("v%0d pulse_len", idx), {bus.vga_valid, bus.cpu_ack}, 0);
    chk($sformatf("v%0d no_regrant", idx), bus.mem_req, 0);
    bus.vga_req = 1'b0;
    bus.cpu_req = 1'b0;
    tick();
    chk($sformatf("v%0d idle", idx), bus.mem_req, 0);
  endtask

  // Transaction-level reference state for the randomized phase.
  logic [31:0] ref_mem [64];
  bit          v_pend, c_pend;
  logic [31:0] v_addr_t, c_addr_t, c_wdata_t;
  logic [3:0]  c_sel_t;
  bit          c_we_t;
  bit          m_busy, m_owner_cpu;
  int          m_cnt;
  bit          e_vv, e_ca, e_mwe;
  logic [31:0] e_maddr, e_mwdata;
  logic [3:0]  e_msel;
  bit          p_vreq, p_creq, p_mbusy;

  initial begin
    nrst = 1'b0;
    bus.vga_req = 0; bus.vga_addr = 0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0; bus.cpu_sel = 0;
    bus.mem_busy = 0;
    for (int i = 0; i < 64; i++) sram[i] = $urandom;
    sram[16] = 32'hFFFFFFFF;
    sram[32] = 32'h12345678;
    sram[33] = 32'h00000000;
    exp_cpu_rdata = 32'd0;

    vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        4'h0, 0, 32'hFFFFFFFF};
    vecs[1] = '{1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 4'h3, 3, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h20, 32'h0,        4'hF, 0, 32'h1234A5A5};
    vecs[3] = '{1'b0, 1'b0, 32'h20, 32'h0,        4'h0, 2, 32'h1234A5A5};
    vecs[4] = '{1'b1, 1'b1, 32'h21, 32'hDEADBEEF, 4'hC, 1, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 32'h21, 32'h0,        4'h0, 0, 32'hDEAD0000};
    vecs[6] = '{1'b1, 1'b1, 32'h21, 32'h0F0F0F0F, 4'hF, 0, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 32'h21, 32'h0,        4'h5, 1, 32'h0F0F0F0F};

    repeat (2) tick();
    chk("reset mem_req", bus.mem_req, 0);
    chk("reset mem_sel", bus.mem_sel, 0);
    chk("reset done", {bus.vga_valid, bus.cpu_ack}, 0);
    chk("reset cpu_rdata", bus.cpu_rdata, 0);
    nrst = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Simultaneous requests with a cleared counter: VGA, then CPU, and the
    // VGA request still held in its done cycle is not served again.
    bus.vga_req = 1; bus.vga_addr = 32'h10;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h20; bus.cpu_sel = 4'hF;
    tick();
    chk("sim first_owner", bus.mem_addr, 32'h10);
    chk("sim first_we", bus.mem_we, 0);
    tick();
    chk("sim vga_valid", bus.vga_valid, 1);
    chk("sim vga_data", bus.vga_data, 32'hFFFFFFFF);
    chk("sim gap", bus.mem_req, 0);
    tick();
    chk("sim second_req", bus.mem_req, 1);
    chk("sim second_owner", bus.mem_addr, 32'h20);
    bus.vga_req = 0;
    tick();
    chk("sim cpu_ack", bus.cpu_ack, 1);
    chk("sim cpu_rdata", bus.cpu_rdata, 32'h1234A5A5);
    exp_cpu_rdata = 32'h1234A5A5;
    bus.cpu_req = 0;
    tick();

    // Reset while a stalled CPU write is in flight.
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'h22;
    bus.cpu_wdata = 32'h11111111; bus.cpu_sel = 4'hF; bus.mem_busy = 1;
    tick();
    chk("rst_mid mem_req_before", bus.mem_req, 1);
    tick();
    #5 nrst = 1'b0;
    #1;
    chk("rst_mid mem_req_async", bus.mem_req, 0);
    chk("rst_mid no_ack", bus.cpu_ack, 0);
    bus.cpu_req = 0; bus.mem_busy = 0;
    tick();
    nrst = 1'b1;
    tick();
    chk("rst_rel mem_req", bus.mem_req, 0);
    chk("rst_rel mem_we", bus.mem_we, 0);
    chk("rst_rel mem_addr", bus.mem_addr, 0);
    chk("rst_rel mem_wdata", bus.mem_wdata, 0);
    chk("rst_rel mem_sel", bus.mem_sel, 0);
    chk("rst_rel vga_data", bus.vga_data, 0);
    chk("rst_rel cpu_rdata", bus.cpu_rdata, 0);
    chk("rst_rel done", {bus.vga_valid, bus.cpu_ack}, 0);
    chk("rst_rel busy", {bus.vga_busy, bus.cpu_busy}, 0);
    exp_cpu_rdata = 32'd0;

    // Randomized traffic: first continuously pending with no stalls, then
    // sparse requests with random SRAM stalls.
    for (int i = 0; i < 64; i++) ref_mem[i] = sram[i];
    v_pend = 0; c_pend = 0; m_busy = 0; m_owner_cpu = 0; m_cnt = 0;
    e_vv = 0; e_ca = 0; e_mwe = 0; e_maddr = 0; e_mwdata = 0; e_msel = 0;
    v_addr_t = 0; c_addr_t = 0; c_wdata_t = 0; c_sel_t = 0; c_we_t = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit cont;
      bit grant_v, grant_c, done, ve, ce, n_vv, n_ca;
      cont = (cyc < 400);
      if (!v_pend && (cont || $urandom_range(0, 2) == 0)) begin
        v_pend = 1; v_addr_t = $urandom;
      end
      if (!c_pend && (cont || $urandom_range(0, 2) == 0)) begin
        c_pend = 1; c_addr_t = $urandom; c_wdata_t = $urandom;
        c_sel_t = 4'($urandom); c_we_t = 1'($urandom);
      end
      bus.vga_req = v_pend | e_vv;
      bus.vga_addr = v_addr_t;
      bus.cpu_req = c_pend | e_ca;
      bus.cpu_we = c_we_t; bus.cpu_addr = c_addr_t;
      bus.cpu_wdata = c_wdata_t; bus.cpu_sel = c_sel_t;
      bus.mem_busy = cont ? 1'b0 : ($urandom_range(0, 3) == 0);
      #1;
      chk("rnd vga_busy", bus.vga_busy, bus.vga_req & ~e_vv);
      chk("rnd cpu_busy", bus.cpu_busy, bus.cpu_req & ~e_ca);
      p_vreq = bus.vga_req; p_creq = bus.cpu_req; p_mbusy = bus.mem_busy;
      tick();

      grant_v = 0; grant_c = 0; done = 0;
      if (m_busy && !p_mbusy) begin
        done = 1;
      end else if (!m_busy) begin
        ve = p_vreq && !e_vv;
        ce = p_creq && !e_ca;
        if (ve && (m_cnt < STARVE_MAX || !ce)) grant_v = 1;
        else if (ce) grant_c = 1;
      end
      if (!p_creq || grant_c) m_cnt = 0;
      else if (grant_v && m_cnt < STARVE_MAX) m_cnt++;
      n_vv = done && !m_owner_cpu;
      n_ca = done && m_owner_cpu;
      if (grant_v) begin
        m_busy = 1; m_owner_cpu = 0; e_maddr = v_addr_t; e_mwe = 0; e_msel = 4'hF;
      end
      if (grant_c) begin
        m_busy = 1; m_owner_cpu = 1; e_maddr = c_addr_t; e_mwe = c_we_t;
        e_msel = c_sel_t; e_mwdata = c_wdata_t;
      end
      if (done) begin
        m_busy = 0; e_mwe = 0;
      end

      chk("rnd vga_valid", bus.vga_valid, n_vv);
      chk("rnd cpu_ack", bus.cpu_ack, n_ca);
      chk("rnd mem_req", bus.mem_req, m_busy);
      chk("rnd mem_we", bus.mem_we, e_mwe);
      if (m_busy) begin
        chk("rnd mem_addr", bus.mem_addr, e_maddr);
        chk("rnd mem_sel", bus.mem_sel, e_msel);
        if (e_mwe) chk("rnd mem_wdata", bus.mem_wdata, e_mwdata);
      end
      if (n_vv) begin
        chk("rnd vga_data", bus.vga_data, ref_mem[v_addr_t[5:0]]);
        v_pend = 0;
      end
      if (n_ca) begin
        if (c_we_t) ref_mem[c_addr_t[5:0]] = merge(ref_mem[c_addr_t[5:0]], c_wdata_t, c_sel_t);
        else exp_cpu_rdata = ref_mem[c_addr_t[5:0]];
        chk("rnd cpu_rdata", bus.cpu_rdata, exp_cpu_rdata);
        c_pend = 0;
      end
      e_vv = n_vv;
      e_ca = n_ca;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
